// File: rtl/vga_sync_pkg.sv
// Shared VGA raster constants: 640x480@60 defaults, counter width, window helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package vga_sync_pkg;

    // Position counters are 10 bits, so each axis total must not exceed 1024.
    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Half-open window test [lo, hi); one extra bit so hi may equal 1024.
    function automatic logic in_window(input logic [CNT_W:0] v,
                                       input logic [CNT_W:0] lo,
                                       input logic [CNT_W:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync/active decode.
// Latency: one clock from en to updated cnt/sync/active; wrap is combinational from cnt.
// Backpressure: none; the counter holds whenever en is low.
module vga_axis_counter
    import vga_sync_pkg::*;
#(
    parameter int ACTIVE   = DEF_H_ACTIVE,
    parameter int FRONT    = DEF_H_FRONT,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BACK     = DEF_H_BACK,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clock,
    input  logic             res,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             sync,
    output logic             active,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W:0]   ACT_END  = (CNT_W+1)'(ACTIVE);
    localparam logic [CNT_W:0]   SYNC_BEG = (CNT_W+1)'(ACTIVE + FRONT);
    localparam logic [CNT_W:0]   SYNC_END = (CNT_W+1)'(ACTIVE + FRONT + SYNC);

    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W:0]   cnt_ext;

    // The counter sits on its last value when the next advance wraps it to 0.
    assign wrap = (cnt == LAST);

    // Next position; the decode below works on it so outputs align with cnt.
    always_comb begin
        cnt_nxt = wrap ? '0 : cnt + 1'b1;
        cnt_ext = {1'b0, cnt_nxt};
    end

    // Reset parks the counter on its last value (blanking), so the first advance lands on 0.
    always_ff @(posedge clock) begin
        if (!res) begin
            cnt    <= LAST;
            sync   <= ~SYNC_POL;
            active <= 1'b0;
        end else if (en) begin
            cnt    <= cnt_nxt;
            sync   <= in_window(cnt_ext, SYNC_BEG, SYNC_END) ? SYNC_POL : ~SYNC_POL;
            active <= (cnt_ext < ACT_END);
        end
    end

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: x/y counters, hsync/vsync, video_on and start-of-frame from a pixel strobe.
// Latency: one clock from pix_en to all updated outputs.
// Backpressure: none; outputs hold while pix_en is low (frame_start drops to 0).
module vga_sync
    import vga_sync_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clock,
    input  logic             res,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start
);

    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;
    logic v_en;

    // The vertical axis steps only on the strobe that takes x from its last value to 0.
    assign v_en = pix_en && h_wrap;

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FRONT    (H_FRONT),
        .SYNC     (H_SYNC),
        .BACK     (H_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_h (
        .clock  (clock),
        .res    (res),
        .en     (pix_en),
        .cnt    (x),
        .sync   (hsync),
        .active (h_active),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FRONT    (V_FRONT),
        .SYNC     (V_SYNC),
        .BACK     (V_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_v (
        .clock  (clock),
        .res    (res),
        .en     (v_en),
        .cnt    (y),
        .sync   (vsync),
        .active (v_active),
        .wrap   (v_wrap)
    );

    // Both per-axis flags are flops updated on the same edge, so their AND stays aligned with x/y.
    assign video_on = h_active && v_active;

    // Pulse for the single clock on which both counters wrap into (0,0).
    always_ff @(posedge clock) begin
        if (!res) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: default 640x480 instance plus a tiny SYNC_POL=1 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_sync;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
    } obs_t;

    typedef struct {
        logic r;
        logic p;
        obs_t exp;
    } vec_t;

    localparam int D_HT  = 800;
    localparam int D_VT  = 525;
    localparam int D_TOT = D_HT * D_VT;

    localparam int S_HA = 8, S_HF = 2, S_HS = 2, S_HB = 2;
    localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_HT  = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT  = S_VA + S_VF + S_VS + S_VB;
    localparam int S_TOT = S_HT * S_VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res_d = 1'b0, pe_d = 1'b0, res_s = 1'b0, pe_s = 1'b0;

    logic       d_hs, d_vs, d_von, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_von, s_fs;
    logic [9:0] s_x, s_y;
    obs_t       d_obs, s_obs;

    assign d_obs = {d_x, d_y, d_hs, d_vs, d_von, d_fs};
    assign s_obs = {s_x, s_y, s_hs, s_vs, s_von, s_fs};

    vga_sync dut (
        .clock       (clk),
        .res         (res_d),
        .pix_en      (pe_d),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .video_on    (d_von),
        .x           (d_x),
        .y           (d_y),
        .frame_start (d_fs)
    );

    vga_sync #(
        .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_POL (1'b1)
    ) dut_s (
        .clock       (clk),
        .res         (res_s),
        .pix_en      (pe_s),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .video_on    (s_von),
        .x           (s_x),
        .y           (s_y),
        .frame_start (s_fs)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a linear raster position (strobes since frame origin, mod frame size).
    int m_d_lp = 0, m_s_lp = 0;
    bit m_d_fs = 1'b0, m_s_fs = 1'b0;

    always @(posedge clk) begin
        if (!res_d) begin
            m_d_lp <= D_TOT - 1;
            m_d_fs <= 1'b0;
        end else if (pe_d) begin
            m_d_lp <= (m_d_lp + 1) % D_TOT;
            m_d_fs <= (m_d_lp == D_TOT - 1);
        end else begin
            m_d_fs <= 1'b0;
        end
        if (!res_s) begin
            m_s_lp <= S_TOT - 1;
            m_s_fs <= 1'b0;
        end else if (pe_s) begin
            m_s_lp <= (m_s_lp + 1) % S_TOT;
            m_s_fs <= (m_s_lp == S_TOT - 1);
        end else begin
            m_s_fs <= 1'b0;
        end
    end

    function automatic obs_t mk(input int xx, input int yy, input bit hs, input bit vs,
                                input bit von, input bit fs);
        obs_t o;
        o.x = 10'(xx);
        o.y = 10'(yy);
        o.hs = hs;
        o.vs = vs;
        o.von = von;
        o.fs = fs;
        return o;
    endfunction

    // Decode a linear position straight from the raster rules.
    function automatic obs_t exp_obs(input int lp, input bit fs,
                                     input int ha, input int hf, input int hs, input int hb,
                                     input int va, input int vf, input int vs, input bit pol);
        int  ht = ha + hf + hs + hb;
        int  xx = lp % ht;
        int  yy = lp / ht;
        bit  h_in = (xx >= ha + hf) && (xx < ha + hf + hs);
        bit  v_in = (yy >= va + vf) && (yy < va + vf + vs);
        return mk(xx, yy, h_in ? pol : !pol, v_in ? pol : !pol, (xx < ha) && (yy < va), fs);
    endfunction

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
                     name, act.x, act.y, act.hs, act.vs, act.von, act.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.fs);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk_obs("dflt_model", d_obs, exp_obs(m_d_lp, m_d_fs, 640, 16, 96, 48, 480, 10, 2, 1'b0));
        chk_obs("small_model", s_obs, exp_obs(m_s_lp, m_s_fs, S_HA, S_HF, S_HS, S_HB,
                                              S_VA, S_VF, S_VS, 1'b1));
    endtask

    // Drive both instances for one clock, then compare just after the edge.
    task automatic cyc(input logic rd, input logic pd, input logic rs, input logic ps);
        res_d = rd;
        pe_d  = pd;
        res_s = rs;
        pe_s  = ps;
        @(posedge clk);
        #1;
        check_all();
    endtask

    vec_t vecs[7];
    obs_t prev;
    obs_t d_rst;
    int von_fall, hs_fall, hs_rise, y_inc_x, y_prev_x, y_new;
    int max_x, hs_hi, hs_bad, vs_hi, vs_bad, von_bad, fs_cnt, strobe;
    int fs_at[3];
    bit found;

    initial begin
        d_rst = mk(799, 524, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[0] = '{1'b0, 1'b0, d_rst};
        vecs[1] = '{1'b0, 1'b1, d_rst};
        vecs[2] = '{1'b1, 1'b0, d_rst};
        vecs[3] = '{1'b1, 1'b1, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1)};
        vecs[4] = '{1'b1, 1'b0, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0)};
        vecs[5] = '{1'b1, 1'b1, mk(1, 0, 1'b1, 1'b1, 1'b1, 1'b0)};
        vecs[6] = '{1'b1, 1'b1, mk(2, 0, 1'b1, 1'b1, 1'b1, 1'b0)};

        // Reset, reset priority, first strobe and frame_start pulse.
        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].p, 1'b0, 1'b0);
            chk_obs($sformatf("vec%0d", i), d_obs, vecs[i].exp);
        end

        // Move to x=300 then stall for 50 clocks.
        repeat (298) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk_obs("at_300", d_obs, mk(300, 0, 1'b1, 1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 50; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (k % 10 == 9) chk_obs("hold", d_obs, mk(300, 0, 1'b1, 1'b1, 1'b1, 1'b0));
        end

        // Rest of the line with a strobe every 4th clock; record edge positions.
        von_fall = -1; hs_fall = -1; hs_rise = -1; y_inc_x = -1; y_prev_x = -1; y_new = -1;
        prev = d_obs;
        for (int k = 0; k < 4000 && y_inc_x < 0; k++) begin
            cyc(1'b1, (k % 4) == 3, 1'b0, 1'b0);
            if (prev.von && !d_obs.von) von_fall = int'(d_obs.x);
            if (prev.hs && !d_obs.hs) hs_fall = int'(d_obs.x);
            if (!prev.hs && d_obs.hs) hs_rise = int'(d_obs.x);
            if (d_obs.y != prev.y) begin
                y_inc_x  = int'(d_obs.x);
                y_prev_x = int'(prev.x);
                y_new    = int'(d_obs.y);
            end
            prev = d_obs;
        end
        chk_int("von_fall_x", von_fall, 640);
        chk_int("hs_fall_x", hs_fall, 656);
        chk_int("hs_rise_x", hs_rise, 752);
        chk_int("y_inc_new_x", y_inc_x, 0);
        chk_int("y_inc_old_x", y_prev_x, 799);
        chk_int("y_inc_val", y_new, 1);

        // Mid-line reset together with a strobe.
        found = 1'b0;
        for (int k = 0; k < 900 && !found; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            found = (d_x == 10'd700);
        end
        chk_int("reach_700", int'(found), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk_obs("midline_reset", d_obs, d_rst);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk_obs("after_reset", d_obs, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1));

        // Small instance: three full frames with a strobe every clock.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_obs("s_reset", s_obs, mk(13, 7, 1'b0, 1'b0, 1'b0, 1'b0));
        max_x = 0; hs_hi = 0; hs_bad = 0; vs_hi = 0; vs_bad = 0; von_bad = 0; fs_cnt = 0;
        for (strobe = 1; strobe <= 3 * S_TOT; strobe++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1);
            if (int'(s_x) > max_x) max_x = int'(s_x);
            if (s_hs) begin
                hs_hi++;
                if (s_x < 10 || s_x > 11) hs_bad++;
            end
            if (s_vs) begin
                vs_hi++;
                if (s_y < 5 || s_y > 6) vs_bad++;
            end
            if (s_von && s_y >= 4) von_bad++;
            if (s_fs) begin
                if (fs_cnt < 3) fs_at[fs_cnt] = strobe;
                fs_cnt++;
            end
        end
        chk_int("s_max_x", max_x, 13);
        chk_int("s_hs_count", hs_hi, 3 * S_VT * 2);
        chk_int("s_hs_outside", hs_bad, 0);
        chk_int("s_vs_count", vs_hi, 3 * 2 * S_HT);
        chk_int("s_vs_outside", vs_bad, 0);
        chk_int("s_von_blank", von_bad, 0);
        chk_int("s_fs_count", fs_cnt, 3);
        chk_int("s_fs_first", fs_at[0], 1);
        chk_int("s_fs_period1", fs_at[1] - fs_at[0], 112);
        chk_int("s_fs_period2", fs_at[2] - fs_at[1], 112);

        // Small instance: reset inside both sync pulses with a strobe in the same clock.
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1);
            found = (s_x == 10'd11) && (s_y == 10'd5);
        end
        chk_int("s_reach_11_5", int'(found), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk_obs("s_mid_reset", s_obs, mk(13, 7, 1'b0, 1'b0, 1'b0, 1'b0));

        // Randomised strobes and occasional resets on both instances against the model.
        for (int k = 0; k < 4000; k++) begin
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 99) != 0, $urandom_range(0, 9) < 6);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
